sfp_row_norm: RTL and testbench

//  Post-processing stage directly downstream of the output FIFO of the MAC array top.

---
 rtl/sfp_row_norm.sv | 189 ++++++++++++++++++
 tb/tb_sfp_row_norm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sfp_row_norm.sv
// sfp_row_norm: L1 row normaliser placed after the MAC-array output FIFO.
// Pops one psum row, sums |lane| over the row, then turns every lane into
// the signed fixed-point ratio lane/sum with one shared serial restoring divider.
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-low reset
//   en              allows a new row to start; a row already in flight is not aborted
//   in_valid, in    FIFO head row (col lanes of bw_psum bits, signed)
//   rd              FIFO pop strobe, combinational, only in IDLE
//   out, out_valid  normalised row (col lanes of obw bits, signed) held until accepted
//   out_ready       consumer accept
//   busy            high whenever the FSM is not idle
//   row_cnt         count of rows accepted on out, wraps at 8 bits
module sfp_row_norm #(
    parameter int unsigned col     = 8,
    parameter int unsigned bw_psum = 20,
    parameter int unsigned frac    = 8,
    parameter int unsigned obw     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [bw_psum*col-1:0]   in,
    output logic                     rd,
    output logic [obw*col-1:0]       out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [7:0]               row_cnt
);

    localparam int unsigned LW  = $clog2(col);
    localparam int unsigned SW  = bw_psum + LW;
    localparam int unsigned STW = $clog2(frac + 1);
    localparam int unsigned DW  = SW + frac;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_DIV,
        S_OUT
    } state_e;

    state_e               state_q, state_d;
    logic [bw_psum-1:0]   row_q [col];
    logic [bw_psum-1:0]   row_d [col];
    logic [obw-1:0]       out_q [col];
    logic [obw-1:0]       out_d [col];
    logic [SW-1:0]        sum_q, sum_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [STW-1:0]       step_q, step_d;
    logic [DW-1:0]        rem_q, rem_d;
    logic [DW-1:0]        den_q, den_d;
    logic [frac-1:0]      quot_q, quot_d;
    logic [7:0]           row_cnt_q, row_cnt_d;

    // Datapath helpers for the lane currently addressed by lane_q
    logic [bw_psum-1:0]   lane_x;
    logic [bw_psum-1:0]   lane_abs;
    logic [DW-1:0]        rem_cur, den_cur;
    logic [frac-1:0]      quot_cur;
    logic                 fits;
    logic [frac:0]        quot_nxt;
    logic [obw-1:0]       q_ext, lane_out;

    // Lane magnitude and one restoring-division step
    always_comb begin
        lane_x   = row_q[lane_q];
        // Unsigned bw_psum-bit magnitude keeps the most negative psum exact
        lane_abs = lane_x[bw_psum-1] ? ((~lane_x) + bw_psum'(1)) : lane_x;
        // Step 0 loads a fresh lane so lanes follow each other without a gap cycle
        rem_cur  = (step_q == '0) ? (DW'(lane_abs) << frac) : rem_q;
        den_cur  = (step_q == '0) ? (DW'(sum_q) << frac) : den_q;
        quot_cur = (step_q == '0) ? '0 : quot_q;
        fits     = (rem_cur >= den_cur);
        quot_nxt = {quot_cur, fits};
        q_ext    = obw'(quot_nxt);
        lane_out = lane_x[bw_psum-1] ? ((~q_ext) + obw'(1)) : q_ext;
    end

    // Next-state and pop strobe
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        out_d     = out_q;
        sum_d     = sum_q;
        lane_d    = lane_q;
        step_d    = step_q;
        rem_d     = rem_q;
        den_d     = den_q;
        quot_d    = quot_q;
        row_cnt_d = row_cnt_q;
        rd        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && en && reset) begin
                    rd = 1'b1;
                    for (int c = 0; c < col; c++) begin
                        row_d[c] = in[c*bw_psum +: bw_psum];
                    end
                    sum_d   = '0;
                    lane_d  = '0;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                sum_d = sum_q + SW'(lane_abs);
                if (lane_q == LW'(col - 1)) begin
                    lane_d = '0;
                    step_d = '0;
                    if (sum_d == '0) begin
                        for (int c = 0; c < col; c++) begin
                            out_d[c] = '0;
                        end
                        state_d = S_OUT;
                    end else begin
                        state_d = S_DIV;
                    end
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            S_DIV: begin
                rem_d  = fits ? (rem_cur - den_cur) : rem_cur;
                den_d  = den_cur >> 1;
                quot_d = quot_nxt[frac-1:0];
                if (step_q == STW'(frac)) begin
                    out_d[lane_q] = lane_out;
                    step_d        = '0;
                    if (lane_q == LW'(col - 1)) begin
                        state_d = S_OUT;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end else begin
                    step_d = step_q + STW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    row_cnt_d = row_cnt_q + 8'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sum_q     <= '0;
            lane_q    <= '0;
            step_q    <= '0;
            rem_q     <= '0;
            den_q     <= '0;
            quot_q    <= '0;
            row_cnt_q <= '0;
            for (int c = 0; c < col; c++) begin
                row_q[c] <= '0;
                out_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            lane_q    <= lane_d;
            step_q    <= step_d;
            rem_q     <= rem_d;
            den_q     <= den_d;
            quot_q    <= quot_d;
            row_cnt_q <= row_cnt_d;
            for (int c = 0; c < col; c++) begin
                row_q[c] <= row_d[c];
                out_q[c] <= out_d[c];
            end
        end
    end

    for (genvar g = 0; g < col; g++) begin : g_out
        assign out[g*obw +: obw] = out_q[g];
    end

    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign row_cnt   = row_cnt_q;

endmodule

// File: tb/tb_sfp_row_norm.sv
// Scoreboard bench for sfp_row_norm: stimulus pushes the hand-computed output
// row when it issues a row; the monitor pops and compares on each out_valid rise.
module tb_sfp_row_norm;

    localparam int unsigned COL = 8;
    localparam int unsigned BW  = 20;
    localparam int unsigned OBW = 10;
    localparam int unsigned IW  = BW * COL;
    localparam int unsigned OW  = OBW * COL;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          rd;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [7:0]    row_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic [OW-1:0] exp_q [$];
    logic          prev_ov = 1'b0;

    sfp_row_norm dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in        (in_data),
        .rd        (rd),
        .out       (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .row_cnt   (row_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_in(input int v[COL]);
        logic [IW-1:0] r;
        r = '0;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(v[c]);
        return r;
    endfunction

    function automatic logic [OW-1:0] mk_out(input int v[COL]);
        logic [OW-1:0] r;
        r = '0;
        for (int c = 0; c < COL; c++) r[c*OBW +: OBW] = OBW'(v[c]);
        return r;
    endfunction

    // Monitor: one comparison per completed row
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_row: got %h want none", out_data);
            end else begin
                chk("row_data", out_data, exp_q.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    // Present a row, wait for the pop, optionally expect its result
    task automatic pop_row(input logic [IW-1:0] row, input logic [OW-1:0] exp, input bit push);
        int n;
        in_data  = row;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!rd && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rd_seen", OW'(rd), OW'(1));
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rd_one_cycle", OW'(rd), OW'(0));
        chk("busy_after_pop", OW'(busy), OW'(1));
        in_valid = 1'b0;
    endtask

    // Count posedges after the pop edge until out_valid
    task automatic wait_valid(input int lat);
        int k;
        k = 0;
        while (!out_valid && k < 300) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            #1;
        end
        chk("latency", OW'(k), OW'(lat));
    endtask

    task automatic finish_xfer();
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        exp_cnt++;
        chk("valid_drop", OW'(out_valid), OW'(0));
        chk("row_cnt", OW'(row_cnt), OW'(exp_cnt));
    endtask

    initial begin
        int v[COL];
        logic [IW-1:0] r100, r400, rneg, r35, rzero, rtrunc;
        logic [OW-1:0] e32, e128, eneg, e35, ezero, etrunc;

        v = '{100, 100, 100, 100, 100, 100, 100, 100}; r100 = mk_in(v);
        v = '{32, 32, 32, 32, 32, 32, 32, 32};         e32  = mk_out(v);
        v = '{400, -400, 0, 0, 0, 0, 0, 0};            r400 = mk_in(v);
        v = '{128, -128, 0, 0, 0, 0, 0, 0};            e128 = mk_out(v);
        v = '{0, 0, 0, -524288, 0, 0, 0, 0};           rneg = mk_in(v);
        v = '{0, 0, 0, -256, 0, 0, 0, 0};              eneg = mk_out(v);
        v = '{0, 0, 0, 3, 0, 1, 0, 0};                 r35  = mk_in(v);
        v = '{0, 0, 0, 192, 0, 64, 0, 0};              e35  = mk_out(v);
        v = '{0, 0, 0, 0, 0, 0, 0, 0};                 rzero = mk_in(v);
        ezero = mk_out(v);
        v = '{1, -1, 1, 0, 0, 0, 0, 0};                rtrunc = mk_in(v);
        v = '{85, -85, 85, 0, 0, 0, 0, 0};             etrunc = mk_out(v);

        // Reset state, with a row offered so rd must stay gated
        reset = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = r100; out_ready = 1'b1;
        #1;
        chk("rst_rd", OW'(rd), OW'(0));
        chk("rst_valid", OW'(out_valid), OW'(0));
        chk("rst_busy", OW'(busy), OW'(0));
        chk("rst_out", out_data, '0);
        chk("rst_cnt", OW'(row_cnt), OW'(0));
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_no_valid_rd", OW'(rd), OW'(0));

        // Uniform, opposite-sign and extreme single-lane rows
        pop_row(r100, e32, 1'b1);  wait_valid(80); finish_xfer();
        pop_row(r400, e128, 1'b1); wait_valid(80); finish_xfer();
        pop_row(rneg, eneg, 1'b1); wait_valid(80); finish_xfer();

        // en drops mid-row: row completes, then no pops until en returns
        pop_row(r35, e35, 1'b1);
        en = 1'b0;
        wait_valid(80); finish_xfer();
        in_data = r100; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("en_low_rd", OW'(rd), OW'(0));
        end
        en = 1'b1;

        // Zero row skips division; truncating row
        pop_row(rzero, ezero, 1'b1);   wait_valid(8);  finish_xfer();
        pop_row(rtrunc, etrunc, 1'b1); wait_valid(80); finish_xfer();

        // Back-pressure: out held, no pops, then pop right after transfer
        out_ready = 1'b0;
        pop_row(r100, e32, 1'b1);
        wait_valid(80);
        in_data = r400; in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            chk("bp_rd", OW'(rd), OW'(0));
            chk("bp_out", out_data, e32);
            chk("bp_valid", OW'(out_valid), OW'(1));
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        exp_cnt++;
        chk("bp_row_cnt", OW'(row_cnt), OW'(exp_cnt));
        chk("bp_rd_after", OW'(rd), OW'(1));
        pop_row(r400, e128, 1'b1); wait_valid(80); finish_xfer();

        // Reset in the middle of division discards the row
        pop_row(r35, e35, 1'b0);
        repeat (30) @(negedge clk);
        in_data = rneg; in_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", OW'(out_valid), OW'(0));
        chk("mid_rst_rd", OW'(rd), OW'(0));
        chk("mid_rst_busy", OW'(busy), OW'(0));
        chk("mid_rst_out", out_data, '0);
        chk("mid_rst_cnt", OW'(row_cnt), OW'(0));
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        pop_row(rneg, eneg, 1'b1); wait_valid(80); finish_xfer();

        repeat (5) @(negedge clk);
        chk("queue_empty", OW'(exp_q.size()), OW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
